boot_mem_responder: RTL

//  Memory-side responder for the 8-bit multicycle CPU bus (adr/writedata/memread/memwrite -> memdata).

---
 rtl/boot_mem_responder_pkg.sv | 14 +
 rtl/boot_mem_responder_if.sv | 30 +++
 rtl/boot_mem_responder_mem_array.sv | 25 ++
 rtl/boot_mem_responder.sv | 104 ++++++++++
 4 files changed

// File: rtl/boot_mem_responder_pkg.sv
// rtl/boot_mem_responder_pkg.sv - shared defaults and FSM encoding for the boot memory responder
package boot_mem_responder_pkg;

  localparam int         DEF_AW      = 8;
  localparam int         DEF_DW      = 8;
  localparam logic [7:0] DEF_IO_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/boot_mem_responder_if.sv
// rtl/boot_mem_responder_if.sv - CPU memory bus plus boot loader byte stream
interface boot_mem_responder_if
  import boot_mem_responder_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) ();

  logic [AW-1:0] adr;
  logic [DW-1:0] writedata;
  logic          memread;
  logic          memwrite;
  logic [DW-1:0] memdata;

  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;

  modport master (
    output adr, writedata, memread, memwrite, ld_valid, ld_data, ld_last,
    input  memdata, ld_ready
  );

  modport slave (
    input  adr, writedata, memread, memwrite, ld_valid, ld_data, ld_last,
    output memdata, ld_ready
  );

endinterface

// File: rtl/boot_mem_responder_mem_array.sv
// rtl/boot_mem_responder_mem_array.sv - 2**AW x DW RAM, synchronous write, asynchronous read
module boot_mem_responder_mem_array #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // No reset: contents survive a responder reset so only the reload overwrites them.
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/boot_mem_responder.sv
// rtl/boot_mem_responder.sv - boot-loads program RAM while holding the CPU in reset, then serves the CPU bus
module boot_mem_responder
  import boot_mem_responder_pkg::*;
#(
  parameter int            AW          = DEF_AW,
  parameter int            DW          = DEF_DW,
  parameter logic [AW-1:0] IO_ADDR     = AW'(DEF_IO_ADDR),
  parameter int            HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  boot_mem_responder_if.slave   bus,
  output logic                  cpu_reset,
  output logic [DW-1:0]         io_out,
  output logic                  io_strobe
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t        state;
  logic [AW-1:0] ptr;
  logic [3:0]    hold_cnt;
  logic          ld_ready_q;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      ptr        <= '0;
      hold_cnt   <= '0;
      cpu_reset  <= 1'b1;
      ld_ready_q <= 1'b1;
      io_out     <= '0;
      io_strobe  <= 1'b0;
    end else begin
      io_strobe <= 1'b0;
      unique case (state)
        ST_LOAD: begin
          if (bus.ld_valid) begin
            ptr <= ptr + AW'(1);
            // Filling the top byte ends the load even without ld_last.
            if (bus.ld_last || (&ptr)) begin
              state      <= ST_HOLD;
              ld_ready_q <= 1'b0;
              hold_cnt   <= '0;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= ST_RUN;
            cpu_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        ST_RUN: begin
          if (bus.memwrite && (bus.adr == IO_ADDR)) begin
            io_out    <= bus.writedata;
            io_strobe <= 1'b1;
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = bus.ld_data;
    if (state == ST_LOAD) begin
      mem_we = bus.ld_valid;
    end else if (state == ST_RUN) begin
      mem_we    = bus.memwrite && (bus.adr != IO_ADDR);
      mem_waddr = bus.adr;
      mem_wdata = bus.writedata;
    end
  end

  boot_mem_responder_mem_array #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (bus.adr),
    .rdata (mem_rdata)
  );

  assign bus.ld_ready = ld_ready_q;
  assign bus.memdata  = ((state == ST_RUN) && bus.memread)
                      ? ((bus.adr == IO_ADDR) ? io_out : mem_rdata)
                      : '0;

endmodule
